// File: rtl/mr_pkg.sv
// Shared memory-subsystem types: arbiter state encoding, default outstanding
// limit and the Wishbone pipelined master-request bundle (also used by the LSU).
package mr_pkg;

  localparam int XLEN      = 32;
  localparam int XLEN_GRAN = 2;
  localparam int ADR_W     = XLEN - XLEN_GRAN;

  localparam int ARB_MAX_OUTS_DEF = 2;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [XLEN-1:0]   dat;
    logic              we;
    logic [XLEN/8-1:0] sel;
    logic              cyc;
    logic              stb;
  } wb_req_t;

endpackage

// File: rtl/mr_arb_pick.sv
// Two-way grant picker. Single requester wins outright; on a tie M1 wins
// unless round-robin is enabled and M1 was the last grantee.
module mr_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  // tie-break: prefer M1 unless round-robin says it had the last turn
  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (rr_en && last) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mr_bus_arb.sv
// Two-master Wishbone pipelined arbiter: M0 = instruction fetch (read only),
// M1 = load/store. The owner keeps the bus while its cyc is high; an
// outstanding counter caps in-flight requests and routes responses.
// Optional feature: define MR_BUS_ARB_RR_EN for round-robin tie-breaking.
module mr_bus_arb
  import mr_pkg::*;
#(
  parameter  int MAX_OUTS = ARB_MAX_OUTS_DEF,
  localparam int OUTS_W   = $clog2(MAX_OUTS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADR_W-1:0]  m0_adr_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [XLEN-1:0]   m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_stall_o,
  input  logic [ADR_W-1:0]  m1_adr_i,
  input  logic [XLEN-1:0]   m1_dat_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_sel_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [XLEN-1:0]   m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_stall_o,
  output logic [ADR_W-1:0]  s_adr_o,
  output logic [XLEN-1:0]   s_dat_o,
  output logic              s_we_o,
  output logic [XLEN/8-1:0] s_sel_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [XLEN-1:0]   s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_stall_i
);

  arb_state_t        state_q, state_d;
  logic [OUTS_W-1:0] count_q, count_d;
  logic [1:0]        gnt;
  logic              last;
  logic              rr_en;
  logic              own0, own1, limit;
  logic              rsp_ok, ack_fwd, err_fwd, accept;
  wb_req_t           m0_req, m1_req, s_req;

  assign own0  = (state_q == ARB_OWN0);
  assign own1  = (state_q == ARB_OWN1);
  assign limit = (count_q == OUTS_W'(MAX_OUTS));

  // M0 never writes: tie its write controls off at the request bundle
  assign m0_req = '{adr: m0_adr_i, dat: '0, we: 1'b0, sel: '1,
                    cyc: m0_cyc_i, stb: m0_stb_i};
  assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, sel: m1_sel_i,
                    cyc: m1_cyc_i, stb: m1_stb_i};

`ifdef MR_BUS_ARB_RR_EN
  logic last_q;

  // remember who was granted most recently for the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= 1'b0;
    else if (state_q == ARB_IDLE && gnt != 2'b00)
      last_q <= gnt[1];
  end

  assign last  = last_q;
  assign rr_en = 1'b1;
`else
  assign last  = 1'b0;
  assign rr_en = 1'b0;
`endif

  mr_arb_pick u_pick (
    .req   ({m1_cyc_i, m0_cyc_i}),
    .last  (last),
    .rr_en (rr_en),
    .gnt   (gnt)
  );

  // state and outstanding-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // next state: grant from IDLE, hold ownership until the owner drops cyc
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt[1])      state_d = ARB_OWN1;
        else if (gnt[0]) state_d = ARB_OWN0;
      end
      ARB_OWN0: if (!m0_cyc_i) state_d = ARB_IDLE;
      ARB_OWN1: if (!m1_cyc_i) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // bus mux toward the slave; stb is withheld while at the outstanding limit
  always_comb begin
    s_req = '0;
    if (own0)      s_req = m0_req;
    else if (own1) s_req = m1_req;
    s_adr_o = s_req.adr;
    s_dat_o = s_req.dat;
    s_we_o  = s_req.we;
    s_sel_o = s_req.sel;
    s_cyc_o = s_req.cyc;
    s_stb_o = s_req.cyc & s_req.stb & ~limit;
  end

  // responses only count while the owner still holds cyc and has requests in flight
  assign rsp_ok  = s_cyc_o & (count_q != '0);
  assign ack_fwd = rsp_ok & s_ack_i;
  assign err_fwd = rsp_ok & s_err_i;
  assign accept  = s_stb_o & ~s_stall_i;

  // outstanding counter; release or error flushes it
  always_comb begin
    count_d = count_q;
    if (!s_cyc_o || err_fwd)
      count_d = '0;
    else if (accept && !ack_fwd)
      count_d = count_q + OUTS_W'(1);
    else if (!accept && ack_fwd)
      count_d = count_q - OUTS_W'(1);
  end

  // response routing and stall generation per master
  always_comb begin
    m0_ack_o   = own0 & ack_fwd;
    m0_err_o   = own0 & err_fwd;
    m0_dat_o   = (own0 && rsp_ok) ? s_dat_i : '0;
    m0_stall_o = own0 ? (s_stall_i | limit) : 1'b1;
    m1_ack_o   = own1 & ack_fwd;
    m1_err_o   = own1 & err_fwd;
    m1_dat_o   = (own1 && rsp_ok) ? s_dat_i : '0;
    m1_stall_o = own1 ? (s_stall_i | limit) : 1'b1;
  end

endmodule
